// File: rtl/axis_pair_packer.sv
// Purpose: packs a 32-bit operand stream into 64-bit {b, a} pair beats; odd packets get PAD_WORD as b.
// Latency: a beat is visible on m_axis the cycle after the input handshake that completes it.
// Backpressure: a 2-beat output buffer; s_axis_tready drops only when that buffer is full.
// Ports:
//   aclk, aresetn           clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tready/tlast   32-bit operand words in
//   m_axis_tdata/tvalid/tready/tlast   64-bit pair beats out, first word in [31:0]
//   pkt_count, odd_count    saturating counts of delivered packets / padded packets
module axis_pair_packer #(
    parameter logic [31:0] PAD_WORD = 32'h0000_0001,
    parameter int          CNT_W    = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [63:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] odd_count
);

    typedef enum logic {ST_LO, ST_HI} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [31:0]      lo_q, lo_d;
    // Slot 0 is the head and drives m_axis directly; slot 1 is the overflow entry.
    logic [63:0]      dat0_q, dat0_d, dat1_q, dat1_d;
    logic             last0_q, last0_d, last1_q, last1_d;
    logic [1:0]       cnt_q, cnt_d;
    // Holds s_axis_tready low during reset and releases it one clock later.
    logic             rdy_q;
    logic [CNT_W-1:0] pkt_q, pkt_d, odd_q, odd_d;

    logic             in_hs, out_hs;
    logic             push, push_last, odd_inc;
    logic [63:0]      push_dat;

    assign s_axis_tready = rdy_q & (cnt_q != 2'd2);
    assign m_axis_tvalid = (cnt_q != 2'd0);
    assign m_axis_tdata  = dat0_q;
    assign m_axis_tlast  = last0_q;
    assign pkt_count     = pkt_q;
    assign odd_count     = odd_q;

    assign in_hs  = s_axis_tvalid & s_axis_tready;
    assign out_hs = m_axis_tvalid & m_axis_tready;

    // Pairing FSM: LO waits for the first word of a pair, HI for the second.
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        push      = 1'b0;
        push_dat  = 64'd0;
        push_last = 1'b0;
        odd_inc   = 1'b0;
        case (state_q)
            ST_LO: begin
                if (in_hs) begin
                    lo_d = s_axis_tdata;
                    if (s_axis_tlast) begin
                        push      = 1'b1;
                        push_dat  = {PAD_WORD, s_axis_tdata};
                        push_last = 1'b1;
                        odd_inc   = 1'b1;
                    end else begin
                        state_d = ST_HI;
                    end
                end
            end
            ST_HI: begin
                if (in_hs) begin
                    push      = 1'b1;
                    push_dat  = {s_axis_tdata, lo_q};
                    push_last = s_axis_tlast;
                    state_d   = ST_LO;
                end
            end
            default: state_d = ST_LO;
        endcase
    end

    // Output buffer. A push never arrives at count 2 because tready is low then.
    always_comb begin
        dat0_d  = dat0_q;
        last0_d = last0_q;
        dat1_d  = dat1_q;
        last1_d = last1_q;
        cnt_d   = cnt_q;
        case ({push, out_hs})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    dat0_d  = push_dat;
                    last0_d = push_last;
                end else begin
                    dat1_d  = push_dat;
                    last1_d = push_last;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                dat0_d  = dat1_q;
                last0_d = last1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    dat0_d  = push_dat;
                    last0_d = push_last;
                end else begin
                    dat0_d  = dat1_q;
                    last0_d = last1_q;
                    dat1_d  = push_dat;
                    last1_d = push_last;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pkt_d = pkt_q;
        odd_d = odd_q;
        if (out_hs && last0_q && (pkt_q != CNT_MAX)) begin
            pkt_d = pkt_q + CNT_W'(1);
        end
        if (odd_inc && (odd_q != CNT_MAX)) begin
            odd_d = odd_q + CNT_W'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_LO;
            lo_q    <= 32'd0;
            dat0_q  <= 64'd0;
            last0_q <= 1'b0;
            dat1_q  <= 64'd0;
            last1_q <= 1'b0;
            cnt_q   <= 2'd0;
            rdy_q   <= 1'b0;
            pkt_q   <= '0;
            odd_q   <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            dat0_q  <= dat0_d;
            last0_q <= last0_d;
            dat1_q  <= dat1_d;
            last1_q <= last1_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
            pkt_q   <= pkt_d;
            odd_q   <= odd_d;
        end
    end

endmodule

// File: tb/tb_axis_pair_packer.sv
`timescale 1ns/1ps
module tb_axis_pair_packer;

    localparam logic [31:0] PAD = 32'h0000_0001;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_dat = 32'd0;
    logic        s_vld = 1'b0;
    logic        s_last = 1'b0;
    logic        m_rdy = 1'b0;

    logic        s_rdy, m_vld, m_last;
    logic [63:0] m_dat;
    logic [15:0] pkt_cnt, odd_cnt;

    logic        s_rdy2, m_vld2, m_last2;
    logic [63:0] m_dat2;
    logic [1:0]  pkt_cnt2, odd_cnt2;

    always #5 aclk = ~aclk;

    axis_pair_packer u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_dat), .s_axis_tvalid(s_vld), .s_axis_tready(s_rdy), .s_axis_tlast(s_last),
        .m_axis_tdata(m_dat), .m_axis_tvalid(m_vld), .m_axis_tready(m_rdy), .m_axis_tlast(m_last),
        .pkt_count(pkt_cnt), .odd_count(odd_cnt)
    );

    axis_pair_packer #(.CNT_W(2)) u_sat (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_dat), .s_axis_tvalid(s_vld), .s_axis_tready(s_rdy2), .s_axis_tlast(s_last),
        .m_axis_tdata(m_dat2), .m_axis_tvalid(m_vld2), .m_axis_tready(m_rdy), .m_axis_tlast(m_last2),
        .pkt_count(pkt_cnt2), .odd_count(odd_cnt2)
    );

    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       got[$];
    int          tests = 0;
    int          fails = 0;
    bit          m_rand = 1'b0;
    logic        m_fixed = 1'b0;
    bit          rdy_exp = 1'b0;
    bit          pend = 1'b0;
    logic [31:0] lo_w = 32'd0;
    int          pkt = 0;
    int          odd = 0;
    bit          ih, oh;
    bit          exp_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input int v, input int mx);
        return 64'((v > mx) ? mx : v);
    endfunction

    // Downstream ready: fixed level or random per cycle.
    initial forever begin
        @(posedge aclk);
        #1;
        m_rdy = m_rand ? 1'($urandom_range(0, 1)) : m_fixed;
    end

    // Reference model and per-cycle comparison. Signals are stable at the
    // falling edge, so the model also predicts the handshakes of the next rising edge.
    initial forever begin
        @(negedge aclk);
        exp_rdy = rdy_exp && (exp_q.size() < 2);
        chk("s_tready", 64'(s_rdy), 64'(exp_rdy));
        chk("m_tvalid", 64'(m_vld), 64'(exp_q.size() != 0));
        chk("sat_s_tready", 64'(s_rdy2), 64'(exp_rdy));
        chk("sat_m_tvalid", 64'(m_vld2), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("m_tdata", m_dat, exp_q[0].d);
            chk("m_tlast", 64'(m_last), 64'(exp_q[0].l));
            chk("sat_m_tdata", m_dat2, exp_q[0].d);
            chk("sat_m_tlast", 64'(m_last2), 64'(exp_q[0].l));
        end
        chk("pkt_count", 64'(pkt_cnt), sat(pkt, 65535));
        chk("odd_count", 64'(odd_cnt), sat(odd, 65535));
        chk("sat_pkt_count", 64'(pkt_cnt2), sat(pkt, 3));
        chk("sat_odd_count", 64'(odd_cnt2), sat(odd, 3));
        if (m_vld && m_rdy) got.push_back('{m_dat, m_last});

        if (!aresetn) begin
            exp_q.delete();
            pend    = 1'b0;
            pkt     = 0;
            odd     = 0;
            rdy_exp = 1'b0;
        end else begin
            ih      = s_vld && exp_rdy;
            oh      = (exp_q.size() != 0) && m_rdy;
            rdy_exp = 1'b1;
            if (oh) begin
                if (exp_q[0].l) pkt++;
                void'(exp_q.pop_front());
            end
            if (ih) begin
                if (!pend) begin
                    if (s_last) begin
                        exp_q.push_back('{{PAD, s_dat}, 1'b1});
                        odd++;
                    end else begin
                        pend = 1'b1;
                        lo_w = s_dat;
                    end
                end else begin
                    exp_q.push_back('{{s_dat, lo_w}, s_last});
                    pend = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic l);
        int n = 0;
        s_dat  = w;
        s_last = l;
        s_vld  = 1'b1;
        while (!s_rdy && n < 500) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (!s_rdy) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: s_tready stayed 0, expected 1");
        end
        @(posedge aclk);
        #1;
        s_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        m_rand  = 1'b0;
        m_fixed = 1'b1;
        while ((exp_q.size() != 0 || m_vld) && n < 1000) begin
            @(posedge aclk);
            #1;
            n++;
        end
        repeat (2) @(posedge aclk);
        #1;
        chk("drain_tvalid", 64'(m_vld), 64'd0);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        s_vld   = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_m_tvalid", 64'(m_vld), 64'd0);
        chk("rst_m_tdata", m_dat, 64'd0);
        chk("rst_m_tlast", 64'(m_last), 64'd0);
        chk("rst_s_tready", 64'(s_rdy), 64'd0);
        chk("rst_pkt_count", 64'(pkt_cnt), 64'd0);
        chk("rst_odd_count", 64'(odd_cnt), 64'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("post_rst_s_tready", 64'(s_rdy), 64'd1);
        got.delete();
    endtask

    task automatic chk_beat(input int i, input logic [63:0] d, input logic l);
        if (got.size() > i) begin
            chk($sformatf("beat%0d_data", i), got[i].d, d);
            chk($sformatf("beat%0d_last", i), 64'(got[i].l), 64'(l));
        end else begin
            tests++;
            fails++;
            $display("FAIL beat%0d_missing: got %0d beats, expected more than %0d", i, got.size(), i);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        m_fixed = 1'b1;

        // T1: even packet
        do_reset();
        send(32'd5, 1'b0); send(32'd10, 1'b0); send(32'd12, 1'b0); send(32'd18, 1'b1);
        drain();
        chk("t1_nbeats", 64'(got.size()), 64'd2);
        chk_beat(0, 64'h0000000A_00000005, 1'b0);
        chk_beat(1, 64'h00000012_0000000C, 1'b1);
        chk("t1_pkt", 64'(pkt_cnt), 64'd1);
        chk("t1_odd", 64'(odd_cnt), 64'd0);

        // T2: odd packet padded
        do_reset();
        send(32'd7, 1'b0); send(32'd14, 1'b0); send(32'd9, 1'b1);
        drain();
        chk("t2_nbeats", 64'(got.size()), 64'd2);
        chk_beat(0, 64'h0000000E_00000007, 1'b0);
        chk_beat(1, 64'h00000001_00000009, 1'b1);
        chk("t2_odd", 64'(odd_cnt), 64'd1);

        // T3: stalled downstream, buffer fills, then release
        do_reset();
        m_fixed = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(32'(100 + i), (i == 5));
            end
            begin
                repeat (30) @(posedge aclk);
                #1;
                chk("t3_stall_s_tready", 64'(s_rdy), 64'd0);
                chk("t3_stall_nbeats", 64'(got.size()), 64'd0);
                chk("t3_stall_tvalid", 64'(m_vld), 64'd1);
                chk("t3_stall_head", m_dat, 64'h00000065_00000064);
                m_fixed = 1'b1;
            end
        join
        drain();
        chk("t3_nbeats", 64'(got.size()), 64'd3);
        chk_beat(0, 64'h00000065_00000064, 1'b0);
        chk_beat(1, 64'h00000067_00000066, 1'b0);
        chk_beat(2, 64'h00000069_00000068, 1'b1);

        // T4: single-word packet, then a pair to show pairing restarts cleanly
        do_reset();
        send(32'd42, 1'b1);
        send(32'd6, 1'b0); send(32'd7, 1'b1);
        drain();
        chk("t4_nbeats", 64'(got.size()), 64'd2);
        chk_beat(0, 64'h00000001_0000002A, 1'b1);
        chk_beat(1, 64'h00000007_00000006, 1'b1);

        // T5: reset mid-pair discards the held word
        do_reset();
        send(32'd3, 1'b0);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        chk("t5_rst_pkt", 64'(pkt_cnt), 64'd0);
        chk("t5_rst_tvalid", 64'(m_vld), 64'd0);
        got.delete();
        send(32'd8, 1'b0); send(32'd4, 1'b1);
        drain();
        chk("t5_nbeats", 64'(got.size()), 64'd1);
        chk_beat(0, 64'h00000004_00000008, 1'b1);
        chk("t5_pkt", 64'(pkt_cnt), 64'd1);

        // T6: counter saturation on the CNT_W=2 instance
        do_reset();
        for (int i = 0; i < 5; i++) send(32'(i + 1), 1'b1);
        drain();
        chk("t6_sat_pkt", 64'(pkt_cnt2), 64'd3);
        chk("t6_sat_odd", 64'(odd_cnt2), 64'd3);
        chk("t6_pkt", 64'(pkt_cnt), 64'd5);
        chk("t6_odd", 64'(odd_cnt), 64'd5);

        // Random traffic with random downstream stalls
        do_reset();
        m_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge aclk);
            #1;
            send($urandom, ($urandom_range(0, 3) == 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
